// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART register-port arbiter.
package uart_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_RWAIT = 1'b1
  } arb_state_e;

  // Master indices; also the bit positions in every 2-bit request/grant vector.
  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  // Read-latency counter width; holds RD_LAT values up to 4.
  localparam int LAT_W = 3;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_port_arbiter_if.sv
// Bundle of both requester ports and the shared UART register port.
// The arbiter connects through 'slave'; the requesters and UART side use 'master'.
interface uart_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  m0_req;
  logic [BE_W-1:0]       m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic [BE_W-1:0]       m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic [BE_W-1:0]       s_wen;
  logic [ADDR_WIDTH-1:0] s_waddr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_ren;
  logic [ADDR_WIDTH-1:0] s_raddr;
  logic [DATA_WIDTH-1:0] s_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  s_wen, s_waddr, s_wdata, s_ren, s_raddr,
    output s_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output s_wen, s_waddr, s_wdata, s_ren, s_raddr,
    input  s_rdata
  );

endinterface

// File: rtl/uart_arb_rr2.sv
// Two-way winner pick: round-robin on last_gnt, or fixed debug priority
// when UART_ARB_FIXED_PRIO_EN is defined. Purely combinational, one-hot output.
module uart_arb_rr2
  import uart_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

`ifdef UART_ARB_FIXED_PRIO_EN
  // Halt-mode debug: master 1 always wins, so the rotation pointer is ignored.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    // NOTE: assign every always_comb output a default first so no path infers a latch.
    gnt = 2'b00;
    if (req[M_DBG])      gnt = onehot2(M_DBG);
    else if (req[M_CPU]) gnt = onehot2(M_CPU);
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (&req)            gnt = onehot2(~last_gnt);
    else if (req[M_DBG]) gnt = onehot2(M_DBG);
    else if (req[M_CPU]) gnt = onehot2(M_CPU);
  end
`endif

endmodule

// File: rtl/uart_port_arbiter.sv
// Serialises CPU and debug accesses onto the UART register port and returns
// read data to the issuer. Optional macro: UART_ARB_FIXED_PRIO_EN (debug wins ties).
module uart_port_arbiter
  import uart_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1    // legal range 1..4
) (
  input  logic               clk,
  input  logic               rst,
  uart_port_arbiter_if.slave bus
);

  localparam int               BE_W     = DATA_WIDTH / 8;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  arb_state_e            state, state_nx;
  logic [LAT_W-1:0]      lat_cnt, lat_cnt_nx;
  logic                  owner, owner_nx;
  logic                  last_gnt, last_gnt_nx;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;

  logic [1:0]            req, win, gnt, rvalid, capture;
  logic                  sel;
  logic [BE_W-1:0]       sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic [BE_W-1:0]       s_wen;
  logic [ADDR_WIDTH-1:0] s_waddr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_ren;
  logic [ADDR_WIDTH-1:0] s_raddr;

  assign req = {bus.m1_req, bus.m0_req};

  uart_arb_rr2 u_rr2 (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (win)
  );

  assign sel       = win[M_DBG];
  assign sel_we    = sel ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      lat_cnt  <= '0;
      owner    <= M_CPU;
      last_gnt <= M_DBG;   // master 0 takes the first tie after reset
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      state    <= state_nx;
      lat_cnt  <= lat_cnt_nx;
      owner    <= owner_nx;
      last_gnt <= last_gnt_nx;
      if (capture[M_CPU]) rdata0 <= bus.s_rdata;
      if (capture[M_DBG]) rdata1 <= bus.s_rdata;
    end
  end

  always_comb begin
    state_nx    = state;
    lat_cnt_nx  = lat_cnt;
    owner_nx    = owner;
    last_gnt_nx = last_gnt;
    gnt         = 2'b00;
    rvalid      = 2'b00;
    capture     = 2'b00;
    s_wen       = '0;
    s_waddr     = '0;
    s_wdata     = '0;
    s_ren       = 1'b0;
    s_raddr     = '0;

    case (state)
      ARB_IDLE: begin
        if (|win) begin
          gnt         = win;
          last_gnt_nx = sel;
          if (|sel_we) begin
            s_wen   = sel_we;
            s_waddr = sel_addr;
            s_wdata = sel_wdata;
          end else begin
            s_ren      = 1'b1;
            s_raddr    = sel_addr;
            owner_nx   = sel;
            lat_cnt_nx = LAT_LOAD;
            state_nx   = ARB_RWAIT;
          end
        end
      end

      ARB_RWAIT: begin
        // Slave data is valid while the counter reads 1; it is registered then,
        // so rdata and rvalid appear together in the cycle the counter hits 0.
        if (lat_cnt != '0) begin
          lat_cnt_nx = lat_cnt - LAT_ONE;
          if (lat_cnt == LAT_ONE) capture[owner] = 1'b1;
        end else begin
          rvalid[owner] = 1'b1;
          state_nx      = ARB_IDLE;
        end
      end

      default: state_nx = ARB_IDLE;
    endcase
  end

  assign bus.m0_gnt    = gnt[M_CPU];
  assign bus.m1_gnt    = gnt[M_DBG];
  assign bus.m0_rvalid = rvalid[M_CPU];
  assign bus.m1_rvalid = rvalid[M_DBG];
  assign bus.m0_rdata  = rdata0;
  assign bus.m1_rdata  = rdata1;
  assign bus.s_wen     = s_wen;
  assign bus.s_waddr   = s_waddr;
  assign bus.s_wdata   = s_wdata;
  assign bus.s_ren     = s_ren;
  assign bus.s_raddr   = s_raddr;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Self-checking bench for uart_port_arbiter: directed scenarios plus random
// traffic, compared each cycle against a timestamp-based transaction model.
module tb_uart_port_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int BW     = DW / 8;
  localparam int RD_LAT = 1;

`ifdef UART_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  uart_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic          req;
    logic [BW-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mreq_t;

  mreq_t         drv [2];
  logic [DW-1:0] slave_mem [16];
  logic [DW-1:0] ref_mem [16];
  bit            slave_pend;
  logic [3:0]    slave_idx;

  // Reference model: a read granted in cycle t returns in cycle t+RD_LAT+1,
  // and no grant is possible up to and including that cycle.
  int            cyc;
  bit            mdl_busy;
  int            mdl_rv_at;
  int            mdl_owner;
  logic [DW-1:0] mdl_rd;
  int            mdl_last;
  logic [DW-1:0] held [2];

  logic [1:0]    obs_gnt, obs_rv;

  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return FIXED ? 1 : 1 - last;
    return r1 ? 1 : 0;
  endfunction

  task automatic set_req(input int m, input logic [BW-1:0] we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    drv[m].req   = 1'b1;
    drv[m].we    = we;
    drv[m].addr  = addr;
    drv[m].wdata = wdata;
  endtask

  task automatic drive_bus();
    bus.m0_req   = drv[0].req;
    bus.m0_we    = drv[0].we;
    bus.m0_addr  = drv[0].addr;
    bus.m0_wdata = drv[0].wdata;
    bus.m1_req   = drv[1].req;
    bus.m1_we    = drv[1].we;
    bus.m1_addr  = drv[1].addr;
    bus.m1_wdata = drv[1].wdata;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst        = 1'b1;
      drv[0].req = 1'b0;
      drv[1].req = 1'b0;
      drive_bus();
      bus.s_rdata = $urandom;
      @(negedge clk);
      cyc++;
    end
    mdl_busy   = 1'b0;
    mdl_last   = 1;
    held[0]    = '0;
    held[1]    = '0;
    slave_pend = 1'b0;
  endtask

  task automatic run_cycle();
    logic [1:0]    eg, erv;
    logic [BW-1:0] ewen;
    logic [AW-1:0] ewa, era;
    logic [DW-1:0] ewd, w_word;
    logic          eren;
    int            w;

    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_bus();
    if (slave_pend) begin
      bus.s_rdata = slave_mem[slave_idx];
      slave_pend  = 1'b0;
    end else begin
      bus.s_rdata = $urandom;
    end
    @(negedge clk);

    eg = '0; erv = '0; ewen = '0; ewa = '0; ewd = '0; eren = 1'b0; era = '0;
    if (mdl_busy) begin
      if (cyc == mdl_rv_at) begin
        erv[mdl_owner] = 1'b1;
        held[mdl_owner] = mdl_rd;
        mdl_busy = 1'b0;
      end
    end else if (drv[0].req || drv[1].req) begin
      w = pick(drv[0].req, drv[1].req, mdl_last);
      eg[w] = 1'b1;
      mdl_last = w;
      if (drv[w].we != '0) begin
        ewen   = drv[w].we;
        ewa    = drv[w].addr;
        ewd    = drv[w].wdata;
        w_word = ref_mem[ewa[3:0]];
        for (int b = 0; b < BW; b++)
          if (ewen[b]) w_word[8*b +: 8] = ewd[8*b +: 8];
        ref_mem[ewa[3:0]] = w_word;
      end else begin
        eren      = 1'b1;
        era       = drv[w].addr;
        mdl_busy  = 1'b1;
        mdl_rv_at = cyc + RD_LAT + 1;
        mdl_owner = w;
        mdl_rd    = ref_mem[era[3:0]];
      end
    end

    obs_gnt = {bus.m1_gnt, bus.m0_gnt};
    obs_rv  = {bus.m1_rvalid, bus.m0_rvalid};
    check("gnt",     32'(obs_gnt),     32'(eg));
    check("rvalid",  32'(obs_rv),      32'(erv));
    check("m0_rdata", bus.m0_rdata,    held[0]);
    check("m1_rdata", bus.m1_rdata,    held[1]);
    check("s_wen",   32'(bus.s_wen),   32'(ewen));
    check("s_waddr", bus.s_waddr,      ewa);
    check("s_wdata", bus.s_wdata,      ewd);
    check("s_ren",   32'(bus.s_ren),   32'(eren));
    check("s_raddr", bus.s_raddr,      era);

    // Slave memory reacts only to what the DUT actually drove.
    if (bus.s_wen != '0) begin
      w_word = slave_mem[bus.s_waddr[3:0]];
      for (int b = 0; b < BW; b++)
        if (bus.s_wen[b]) w_word[8*b +: 8] = bus.s_wdata[8*b +: 8];
      slave_mem[bus.s_waddr[3:0]] = w_word;
    end
    if (bus.s_ren) begin
      slave_pend = 1'b1;
      slave_idx  = bus.s_raddr[3:0];
    end
    cyc++;
  endtask

  int order[$];
  int k;

  initial begin
    logic [DW-1:0] v;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      drv[i].req = 1'b0; drv[i].we = '0; drv[i].addr = '0; drv[i].wdata = '0;
    end
    drive_bus();
    bus.s_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      slave_mem[i] = v;
      ref_mem[i]   = v;
    end
    slave_mem[5] = 32'h60;
    ref_mem[5]   = 32'h60;

    do_reset(2);
    run_cycle();
    check("rst_gnt", 32'(obs_gnt), 32'h0);
    check("rst_rdata1", bus.m1_rdata, 32'h0);

    // Lone CPU write: same-cycle grant onto the slave port.
    set_req(0, 4'hF, 32'h1FE0_01E0, 32'h41);
    run_cycle();
    check("wr_gnt", 32'(obs_gnt), 32'h1);
    check("wr_wen", 32'(bus.s_wen), 32'hF);
    check("wr_waddr", bus.s_waddr, 32'h1FE0_01E0);
    drv[0].req = 1'b0;

    // Lone debug read: rvalid exactly RD_LAT+1 cycles after the grant.
    set_req(1, '0, 32'h1FE0_01E5, '0);
    run_cycle();
    check("rd_gnt", 32'(obs_gnt), 32'h2);
    drv[1].req = 1'b0;
    run_cycle();
    check("rd_early", 32'(obs_rv), 32'h0);
    run_cycle();
    check("rd_rvalid", 32'(obs_rv), 32'h2);
    check("rd_data", bus.m1_rdata, 32'h60);

    // Both masters hold reads: grants alternate starting with the CPU.
    do_reset(1);
    set_req(0, '0, 32'h1FE0_01E3, '0);
    set_req(1, '0, 32'h1FE0_01E7, '0);
    order.delete();
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      run_cycle();
      if (obs_gnt[0]) order.push_back(0);
      if (obs_gnt[1]) order.push_back(1);
    end
    check("rr_rd_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++)
      check("rr_rd_order", 32'(order[i]), FIXED ? 32'd1 : 32'(i % 2));
    drv[0].req = 1'b0;
    drv[1].req = 1'b0;
    repeat (3) run_cycle();

    // Both masters hold writes: one write per cycle, alternating.
    set_req(0, 4'hF, 32'h1FE0_01E1, 32'hA5A5_0001);
    set_req(1, 4'h3, 32'h1FE0_01E2, 32'h5A5A_0002);
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      check("rr_wr_gnt", 32'(obs_gnt), FIXED ? 32'h2 : ((i % 2) ? 32'h2 : 32'h1));
      check("rr_wr_active", 32'(bus.s_wen != '0), 32'h1);
    end
    drv[0].req = 1'b0;
    drv[1].req = 1'b0;

    // Reset while a CPU read is outstanding: the read is abandoned.
    set_req(0, '0, 32'h1FE0_01E4, '0);
    run_cycle();
    check("abort_gnt", 32'(obs_gnt), 32'h1);
    drv[0].req = 1'b0;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      check("abort_no_rv", 32'(obs_rv), 32'h0);
    end
    set_req(0, 4'h1, 32'h1FE0_01E8, 32'h11);
    set_req(1, 4'h1, 32'h1FE0_01E9, 32'h22);
    run_cycle();
    check("abort_tie", 32'(obs_gnt), FIXED ? 32'h2 : 32'h1);
    drv[0].req = 1'b0;
    drv[1].req = 1'b0;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Debug priority: CPU starves while the debug request stays high.
    set_req(0, 4'hF, 32'h1FE0_01E0, 32'h33);
    set_req(1, 4'hF, 32'h1FE0_01E1, 32'h44);
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      check("prio_gnt", 32'(obs_gnt), 32'h2);
    end
    drv[1].req = 1'b0;
    run_cycle();
    check("prio_release", 32'(obs_gnt), 32'h1);
    drv[0].req = 1'b0;
`endif

    // Random traffic: requests held until granted, occasionally withdrawn.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset(1);
      for (int m = 0; m < 2; m++) begin
        if (!drv[m].req) begin
          if ($urandom_range(0, 2) != 0) begin
            k = $urandom_range(0, 1);
            set_req(m, (k == 0) ? '0 : BW'($urandom_range(1, 15)), $urandom, $urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          drv[m].req = 1'b0;
        end
      end
      run_cycle();
      for (int m = 0; m < 2; m++)
        if (obs_gnt[m]) drv[m].req = 1'b0;
    end
    drv[0].req = 1'b0;
    drv[1].req = 1'b0;
    repeat (4) run_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_port_arbiter.md
Name: uart_port_arbiter

Overview:
- Two-requester arbiter for the UART's SRAM-style register port (we/waddr/data_i/raddr/re/data_o).
- Master 0 is the AXI-to-SRAM bridge path (CPU); master 1 is the debug/loader path.
- Serialises accesses, routes read data back to the issuer, and guarantees round-robin fairness.
- Sits between the bridge/debug logic and the uart instance inside the UART wrapper.

Parameters:
- ADDR_WIDTH, 32, address width of masters and slave port.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits.
- RD_LAT, 1, slave read latency in cycles from re to valid data_o; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m0_req  in  1  master 0 request; held with its fields until m0_gnt.
- m0_we  in  DATA_WIDTH/8  byte write enables; zero means read.
- m0_addr  in  ADDR_WIDTH  access address.
- m0_wdata  in  DATA_WIDTH  write data.
- m0_gnt  out  1  one-cycle pulse: request accepted and issued to slave this cycle.
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid.
- m0_rdata  out  DATA_WIDTH  read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for master 1.
- s_wen  out  DATA_WIDTH/8  slave byte write enables.
- s_waddr  out  ADDR_WIDTH  slave write address.
- s_wdata  out  DATA_WIDTH  slave write data.
- s_ren  out  1  slave read strobe.
- s_raddr  out  ADDR_WIDTH  slave read address.
- s_rdata  in  DATA_WIDTH  slave read data, valid RD_LAT cycles after s_ren.

Behaviour:
- Single clock, synchronous active-high reset.
- States are IDLE and RWAIT.
  - In IDLE with any req, a winner is chosen combinationally; its gnt pulses and its fields drive s_* in the same cycle.
    - Nonzero we: s_wen = we, s_waddr/s_wdata driven, state stays IDLE. Back-to-back writes run at 1 per cycle.
    - Zero we: s_ren = 1, s_raddr = addr, owner is registered, latency counter loads RD_LAT, state goes to RWAIT.
  - In RWAIT, no grants are issued; the counter decrements each cycle. When it reaches 0, s_rdata is captured into owner rdata with owner rvalid = 1 for that cycle, and state returns to IDLE. A new grant is possible in the following cycle.
  - Read turnaround is RD_LAT+1 cycles from gnt to rvalid.
- Arbitration is round-robin.
  - A last_gnt pointer updates on every grant.
  - When both masters request, the master not equal to last_gnt wins.
  - A lone requester always wins.
- Outputs not driven by a grant are 0; s_* hold 0 when idle.
- rdata outputs hold their last captured value; they change only on that master's rvalid.
- Reset values: all gnt, rvalid, s_wen, s_ren = 0; s_* addresses and data = 0; rdata = 0; state IDLE; counter 0; last_gnt = 1, so master 0 wins the first tie.
- Reset asserted in RWAIT abandons the pending read: no rvalid is produced and the slave data is ignored.
- A req that drops before gnt is legal; the request is withdrawn with no side effect.
- A req held high in RWAIT waits; it is not lost.
- Requests arriving the same cycle rvalid fires are arbitrated in the next cycle (IDLE).

Optional Feature:
- Macro UART_ARB_FIXED_PRIO_EN.
- Defined: master 1 (debug) always wins ties and last_gnt is unused. Master 0 can starve while m1_req is continuously high; this is intended for halt-mode debug.
- Undefined: round-robin as above.

Decomposition:
- Shared package uart_arb_pkg:
  - state encoding constants ARB_IDLE / ARB_RWAIT.
  - master index constants M_CPU = 0, M_DBG = 1.
  - RD_LAT counter width constant (3 bits).
- One natural sub-module, uart_arb_rr2: 2-way round-robin/priority pick, combinational on req plus last_gnt, returning a one-hot grant. The FIXED_PRIO macro is resolved inside it.
- The top level holds the FSM, counter, owner register and data routing.

Test Plan:
- m0 write we=4'hF addr=0x1FE001E0 wdata=0x41, m1 idle -> same-cycle m0_gnt, s_wen=F, s_waddr/s_wdata matched, no rvalid.
- m1 read addr=0x1FE001E5, slave returns 0x60 at RD_LAT=1 -> m1_gnt at t0, s_ren at t0, m1_rvalid at t0+2 with m1_rdata=0x60; m0_rvalid stays 0.
- Both masters hold reads continuously for 6 grants after reset -> grant order m0, m1, m0, m1, m0, m1; no grant during RWAIT.
- Both masters hold writes -> alternating gnt every cycle, 1 write per cycle on s_wen.
- m0 read granted, rst pulsed during RWAIT -> no m0_rvalid ever; after reset a tie grants m0 first.
- With UART_ARB_FIXED_PRIO_EN, both masters requesting writes for 4 cycles -> m1_gnt all 4 cycles, m0_gnt 0 until m1_req drops.
